// File: rtl/sha256d_pkg.sv
// Constants, state encoding and byte-order helpers shared by the sha256d nonce scheduler.
package sha256d_pkg;

    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] PAD_ONE      = 32'h8000_0000;
    localparam logic [63:0] HDR_LEN_BITS = 64'd640;
    localparam logic [63:0] DIG_LEN_BITS = 64'd256;

    typedef enum logic [2:0] {
        ST_IDLE, ST_MID, ST_BLK1, ST_HASH2, ST_CHECK, ST_DONE, ST_ERR
    } state_t;

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [255:0] bswap256(input logic [255:0] x);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255-8*i -: 8];
        return r;
    endfunction

endpackage

// File: rtl/sha256d_nonce_sched.sv
// Purpose: drives a shared SHA-256 compression core through sha256d over a nonce range, midstate cached.
// Latency: 1 MID pass, then per nonce 2 core passes + 1 CHECK cycle (plus core_ready stalls).
// Backpressure: core_start only issued while core_ready=1; a core_done missing for TIMEOUT_CYC cycles -> ERR.
module sha256d_nonce_sched
    import sha256d_pkg::*;
#(
    parameter int TIMEOUT_CYC = 128,
    parameter int CNT_W       = 8
) (
    input  logic         ACLK,
    input  logic         ARESETN,
    input  logic         start,
    input  logic         abort,
    input  logic [639:0] hdr_i,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic [255:0] target_i,
    input  logic         core_ready,
    output logic         core_start,
    output logic [255:0] core_chain,
    output logic [511:0] core_block,
    input  logic         core_done,
    input  logic [255:0] core_digest,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic         err,
    output logic [31:0]  found_nonce,
    output logic [255:0] result_hash
);

    state_t             state, state_nxt;
    logic [607:0]       hdr_q;
    logic [31:0]        nonce_q, nonce_end_q;
    logic [255:0]       target_q, midstate_q, digest1_q, digest2_q;
    logic               issued;
    logic [CNT_W-1:0]   tmo_cnt;

    logic start_ok, empty_range, wait_st, done_acc, timeout, hit, last_nonce;

    // The header's own nonce field is always replaced by the swept nonce.
    logic unused_hdr_nonce;
    assign unused_hdr_nonce = ^hdr_i[31:0];

    assign start_ok    = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    assign empty_range = nonce_end < nonce_start;
    assign wait_st     = state inside {ST_MID, ST_BLK1, ST_HASH2};
    assign done_acc    = wait_st && issued && core_done;
    assign timeout     = wait_st && issued && !core_done && (tmo_cnt == CNT_W'(TIMEOUT_CYC));
    assign hit         = bswap256(digest2_q) <= target_q;
    assign last_nonce  = nonce_q == nonce_end_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: if (start) state_nxt = empty_range ? ST_DONE : ST_MID;
                ST_MID:   if (done_acc) state_nxt = ST_BLK1;  else if (timeout) state_nxt = ST_ERR;
                ST_BLK1:  if (done_acc) state_nxt = ST_HASH2; else if (timeout) state_nxt = ST_ERR;
                ST_HASH2: if (done_acc) state_nxt = ST_CHECK; else if (timeout) state_nxt = ST_ERR;
                ST_CHECK: state_nxt = (hit || last_nonce) ? ST_DONE : ST_BLK1;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = wait_st || (state == ST_CHECK);
        done       = state == ST_DONE;
        err        = state == ST_ERR;
        // Suppressed under abort so no orphan core job is launched on the way to IDLE.
        core_start = wait_st && !issued && core_ready && !abort;
        core_chain = '0;
        core_block = '0;
        case (state)
            ST_MID: begin
                core_chain = SHA256_IV;
                core_block = hdr_q[607:96];
            end
            ST_BLK1: begin
                core_chain = midstate_q;
                core_block = {hdr_q[95:0], bswap32(nonce_q), PAD_ONE, 288'b0, HDR_LEN_BITS};
            end
            ST_HASH2: begin
                core_chain = SHA256_IV;
                core_block = {digest1_q, PAD_ONE, 160'b0, DIG_LEN_BITS};
            end
            default: ;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            hdr_q       <= '0;
            nonce_q     <= '0;
            nonce_end_q <= '0;
            target_q    <= '0;
            midstate_q  <= '0;
            digest1_q   <= '0;
            digest2_q   <= '0;
            issued      <= 1'b0;
            tmo_cnt     <= '0;
            found       <= 1'b0;
            found_nonce <= '0;
            result_hash <= '0;
        end else if (abort) begin
            issued  <= 1'b0;
            tmo_cnt <= '0;
            found   <= 1'b0;
        end else begin
            if (start_ok) begin
                hdr_q       <= hdr_i[639:32];
                nonce_q     <= nonce_start;
                nonce_end_q <= nonce_end;
                target_q    <= target_i;
                found       <= 1'b0;
                issued      <= 1'b0;
                tmo_cnt     <= '0;
            end
            // tmo_cnt holds the number of cycles elapsed since core_start.
            if (core_start) begin
                issued  <= 1'b1;
                tmo_cnt <= CNT_W'(1);
            end else if (done_acc || timeout) begin
                issued  <= 1'b0;
                tmo_cnt <= '0;
            end else if (issued) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (done_acc) begin
                case (state)
                    ST_MID:   midstate_q <= core_digest;
                    ST_BLK1:  digest1_q  <= core_digest;
                    ST_HASH2: digest2_q  <= core_digest;
                    default:  ;
                endcase
            end
            if (state == ST_CHECK) begin
                found_nonce <= nonce_q;
                result_hash <= digest2_q;
                found       <= hit;
                if (!hit && !last_nonce) nonce_q <= nonce_q + 1'b1;
            end
        end
    end

endmodule
